// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming (7,4) receive path.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
//
// CW_BITS  : codeword width, shared with the downstream decoder stage.
// rx_state_t : serial framer states.
// CNT_W    : width of a counter that spans 0..div-1.
package hamming_pkg;

    localparam int CW_BITS = 7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic int CNT_W(input int div);
        return $clog2(div);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running.
//
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized output).
// RST_VAL sets the reset level of both flops so an idle-high line reads idle out of reset.
module bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hamming_rx.sv
// Serial framer: start + 7 data bits (LSB first) + stop, delivered as du[7:1].
// Latency: about 2 + DIV/2 + 8*DIV clocks from start-bit fall to du_valid.
// Backpressure: one-entry output register; a word completing while it is full is dropped (overrun).
//
// Ports: clk, rst_n (async active-low), rx (async serial line, idle 1),
//        du/du_valid/du_ready (registered valid/ready codeword output),
//        frame_err (1-cycle pulse, bad stop bit), overrun (1-cycle pulse, word dropped).
module hamming_rx
    import hamming_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    output logic [CW_BITS:1] du,
    output logic             du_valid,
    input  logic             du_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int            CW       = CNT_W(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(DIV / 2 - 1);
    localparam logic [2:0]    IDX_LAST = 3'(CW_BITS - 1);

    logic             rxs;
    rx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       idx_q;
    logic [CW_BITS:1] sr_q;

    logic cnt_clr;
    logic samp_data;
    logic load;
    logic ferr_d;
    logic ovr_d;
    logic reg_free;

    bit_sync #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    // A transfer in the same cycle frees the slot for a new load.
    assign reg_free = !du_valid || du_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        samp_data = 1'b0;
        load      = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) state_d = START;
            end
            START: begin
                // Mid-bit recheck rejects glitches shorter than half a bit.
                if (cnt_q == CNT_MID) state_d = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    samp_data = 1'b1;
                    if (idx_q == IDX_LAST) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    if (!rxs)          ferr_d = 1'b1;
                    else if (reg_free) load   = 1'b1;
                    else               ovr_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter restarts on every state change so each state times from its own entry.
    assign cnt_clr = (state_d != state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            sr_q  <= '0;
        end else begin
            if (cnt_clr || cnt_q == CNT_LAST) cnt_q <= '0;
            else                              cnt_q <= cnt_q + 1'b1;

            if (state_q != DATA) idx_q <= '0;
            else if (samp_data)  idx_q <= idx_q + 1'b1;

            // Shift in from the top: after seven samples the first bit sits in sr_q[1].
            if (samp_data) sr_q <= {rxs, sr_q[CW_BITS:2]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            du        <= '0;
            du_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                du       <= sr_q;
                du_valid <= 1'b1;
            end else if (du_ready) begin
                du_valid <= 1'b0;
            end
            frame_err <= ferr_d;
            overrun   <= ovr_d;
        end
    end

endmodule

// File: doc/hamming_rx.md
# hamming_rx

Serial receiver that sits directly upstream of the Hamming (7,4) decoder. It samples an asynchronous one-wire serial line and assembles one framed 7-bit codeword at a time. Each codeword is presented as `du[7:1]` through a one-entry valid/ready output register, which feeds the decoder's `du` input. The block also flags framing errors and dropped words (overrun).

## Interface
- `DIV`, 16: clock cycles per serial bit. Legal range 4..1024.
- `clk` in 1: single clock. All logic runs on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx` in 1: serial line, asynchronous to `clk`. Idle level is 1.
- `du` out 7 (`[7:1]`): received codeword. Bit `du[1]` is the first data bit on the wire.
- `du_valid` out 1: `du` holds an unconsumed codeword.
- `du_ready` in 1: consumer accepts `du` in any cycle where `du_valid && du_ready`.
- `frame_err` out 1: one-cycle pulse; stop bit sampled as 0, word discarded.
- `overrun` out 1: one-cycle pulse; word completed while the output register was full, new word discarded.

## Operation
- **Frame format:** start bit (0), then 7 data bits with `du[1]` first and `du[7]` last, then stop bit (1). No parity.
- **Synchronizer:** `rx` passes through a 2-flop synchronizer, reset value 1. All FSM decisions use the synchronized signal `rxs`.
- **Bit counter:** counts 0..DIV-1 and is cleared on every state entry. The data-bit index counts 0..6.
- **FSM states:**
  - IDLE: a cycle with `rxs`==0 moves to START and clears the counter.
  - START: at count == DIV/2 - 1 (mid start bit), sample `rxs`. If 1, this is a false start: go back to IDLE with no output activity. If 0, go to DATA and clear the counter.
  - DATA: at each count == DIV-1, shift `rxs` into the shift register at position index+1. After index 6 is sampled, go to STOP.
  - STOP: at count == DIV-1, sample `rxs`.
    - If 0: pulse `frame_err`, discard the word, go to IDLE.
    - If 1 and the output register is free: load `du`, set `du_valid`, go to IDLE.
    - If 1 and the output register is full: pulse `overrun`, keep the old `du`, go to IDLE.
- **Output register free:** true when `du_valid`==0, or when a transfer (`du_valid && du_ready`) happens in the same cycle.
- **Simultaneous transfer and load:** the new word is loaded, `du_valid` stays 1, and `overrun` does not pulse.
- **Register behaviour:** `du` changes only on a load. `du_valid` clears on a transfer with no simultaneous load.
- **During a frame:** `frame_err`/`overrun` never affect a frame already in progress. IDLE re-arms immediately, so a back-to-back start bit right after the stop sample is accepted.

## Timing
- **Reset values:** `du`=0, `du_valid`=0, `frame_err`=0, `overrun`=0. FSM in IDLE, counters 0, synchronizer flops 1.
- **Reset mid-frame:** the partial word is lost. After `rst_n` rises, no output activity occurs until a new falling edge.
- **Latency:** the `rx` edge reaches `rxs` after 2 clocks. `du_valid` rises on the clock after the stop-bit sample edge. Total time from the `rx` start-bit falling edge to `du_valid` is about 2 + DIV/2 + 8·DIV clocks.
- **Error pulses:** `frame_err` and `overrun` are registered and high for exactly one cycle, the cycle in which `du_valid` would have risen.
- **Handshake:** `du` and `du_valid` are registered outputs, with no combinational path from `du_ready`. `du_ready` may be held high permanently.

## Structure
- **`hamming_pkg`:** holds `CW_BITS` = 7, the FSM state enum (IDLE, START, DATA, STOP), and `CNT_W(DIV)` = $clog2(DIV). The decoder stage shares `CW_BITS`.
- **Sub-module `bit_sync`:** 2-flop synchronizer with a reset-value parameter. It is reused by other asynchronous inputs in the design.
- **Remaining logic in `hamming_rx`:** the FSM, bit/index counters, shift register and output register.

## Test plan
- **Clean frame:** DIV=4, `du_ready`=1, send 7'b1010101 framed → one `du_valid` pulse with `du`=7'h55. The downstream decoder shows NOERROR=1.
- **False start:** DIV=16, drive `rx` low for 5 clocks then high → FSM returns to IDLE; `du_valid`, `frame_err` and `overrun` all stay 0.
- **Frame error:** send 7'h2A with stop bit 0 → `frame_err` high for 1 cycle; `du_valid` stays 0 and `du` is unchanged.
- **Overrun:** `du_ready`=0, send 7'h11 then 7'h22 → `du`=7'h11, `du_valid`=1, and `overrun` pulses once at the end of the second frame. Raising `du_ready` then gives one transfer of 7'h11.
- **Simultaneous transfer and load:** hold 7'h11 valid, and assert `du_ready` exactly in the stop-sample cycle of frame 7'h22 → `du` becomes 7'h22, `du_valid` stays 1, no `overrun`.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 3 → all outputs read 0 immediately. After release, a full frame of 7'h7F is received correctly.
